// File: rtl/fallthrough_fifo_small.sv
// Small first-word-fall-through FIFO: the oldest stored word is always visible on dout,
// and rd_en simply pops it. Flags are decoded from a registered occupancy counter.
module fallthrough_fifo_small #(
  parameter int WIDTH               = 72,
  parameter int MAX_DEPTH_BITS      = 3,
  parameter int PROG_FULL_THRESHOLD = (2 ** MAX_DEPTH_BITS) - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             prog_full,
  output logic             empty
);

  localparam int DEPTH = 2 ** MAX_DEPTH_BITS;
  localparam int CW    = MAX_DEPTH_BITS + 1;

  localparam logic [CW-1:0]             DEPTH_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0]             NEARLY_CNT = CW'(DEPTH - 1);
  localparam logic [CW-1:0]             CNT_ONE    = CW'(1);
  localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE    = MAX_DEPTH_BITS'(1);

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [CW-1:0]             count;
  logic                      rd_ok;
  logic                      wr_ok;

  // A pop frees a slot in the same edge, so a full FIFO can still take a write alongside a read.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  assign empty       = (count == '0);
  assign full        = (count == DEPTH_CNT);
  assign nearly_full = (count >= NEARLY_CNT);
  assign prog_full   = (int'(count) >= PROG_FULL_THRESHOLD);

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fallthrough_fifo_small.sv
// Bench for fallthrough_fifo_small: a queue-based model predicts contents and occupancy;
// a negedge monitor compares flags and the head word, popping expected words as reads retire.
module tb_fallthrough_fifo_small;

  localparam int WIDTH = 8;
  localparam int MDB   = 2;
  localparam int DEPTH = 4;
  localparam int PFT   = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             nearly_full;
  logic             prog_full;
  logic             empty;

  int checks = 0;
  int errors = 0;
  bit monitor_on = 1'b0;

  logic [WIDTH-1:0] sb_q[$];
  int               model_count = 0;

  fallthrough_fifo_small #(
    .WIDTH(WIDTH),
    .MAX_DEPTH_BITS(MDB),
    .PROG_FULL_THRESHOLD(PFT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .din(din),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .dout(dout),
    .full(full),
    .nearly_full(nearly_full),
    .prog_full(prog_full),
    .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit w, input bit r, input logic [WIDTH-1:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic doReset(input bit w, input logic [WIDTH-1:0] d);
    reset = 1'b1;
    wr_en = w;
    rd_en = 1'b0;
    din   = d;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr_en = 1'b0;
  endtask

  // Reference model: acceptance rules applied to a plain occupancy number; accepted writes queue expected words.
  always @(posedge clk) begin
    bit r_ok;
    bit w_ok;
    if (reset) begin
      model_count = 0;
      sb_q.delete();
    end else begin
      r_ok = rd_en && (model_count > 0);
      w_ok = wr_en && ((model_count < DEPTH) || r_ok);
      if (w_ok) sb_q.push_back(din);
      model_count = model_count + int'(w_ok) - int'(r_ok);
    end
  end

  // Monitor: flags against occupancy thresholds, head word against the oldest expected word.
  always @(negedge clk) begin
    logic [3:0] exp_flags;
    if (monitor_on) begin
      exp_flags = {model_count == DEPTH, model_count >= DEPTH - 1, model_count >= PFT, model_count == 0};
      checkOutput("flags{full,nearly,prog,empty}", {28'd0, full, nearly_full, prog_full, empty}, {28'd0, exp_flags});
      if (model_count > 0) begin
        checkOutput("dout_head", {24'd0, dout}, {24'd0, sb_q[0]});
        if (rd_en && !reset) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset      = 1'b0;
    monitor_on = 1'b1;
    checkOutput("reset_empty", {31'd0, empty}, 32'd1);
    checkOutput("reset_full", {31'd0, full}, 32'd0);
    checkOutput("reset_nearly", {31'd0, nearly_full}, 32'd0);
    checkOutput("reset_prog", {31'd0, prog_full}, 32'd0);

    // Single word fall-through and pop
    applyStimulus(1'b1, 1'b0, 8'hA5);
    checkOutput("a5_empty", {31'd0, empty}, 32'd0);
    checkOutput("a5_dout", {24'd0, dout}, 32'hA5);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("a5_popped_empty", {31'd0, empty}, 32'd1);

    // Fill to full, overflow dropped, drain in order
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b0, 8'(i));
    checkOutput("three_nearly", {31'd0, nearly_full}, 32'd1);
    checkOutput("three_prog", {31'd0, prog_full}, 32'd1);
    checkOutput("three_full", {31'd0, full}, 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h04);
    checkOutput("four_full", {31'd0, full}, 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h05);
    checkOutput("overflow_full", {31'd0, full}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("drain_order", {24'd0, dout}, 32'(i));
      applyStimulus(1'b0, 1'b1, 8'h00);
    end
    checkOutput("drained_empty", {31'd0, empty}, 32'd1);

    // Simultaneous read and write while full
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'(8'h10 + i));
    applyStimulus(1'b1, 1'b1, 8'h14);
    checkOutput("full_rw_full", {31'd0, full}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("full_rw_order", {24'd0, dout}, 32'(8'h10 + i));
      applyStimulus(1'b0, 1'b1, 8'h00);
    end

    // Underflow ignored, then read+write while empty keeps the write
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput("underflow_empty", {31'd0, empty}, 32'd1);
    end
    applyStimulus(1'b1, 1'b1, 8'h77);
    checkOutput("empty_rw_empty", {31'd0, empty}, 32'd0);
    checkOutput("empty_rw_dout", {24'd0, dout}, 32'h77);
    applyStimulus(1'b0, 1'b1, 8'h00);

    // Streaming across pointer wrap
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h01);
    for (int i = 2; i < 10; i++) applyStimulus(1'b1, 1'b1, 8'(i));
    checkOutput("stream_head", {24'd0, dout}, 32'h08);
    repeat (2) applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("stream_empty", {31'd0, empty}, 32'd1);

    // Reset mid-operation beats a concurrent write
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'(8'h30 + i));
    doReset(1'b1, 8'h99);
    checkOutput("mid_reset_empty", {31'd0, empty}, 32'd1);
    checkOutput("mid_reset_full", {31'd0, full}, 32'd0);
    checkOutput("mid_reset_nearly", {31'd0, nearly_full}, 32'd0);
    checkOutput("mid_reset_prog", {31'd0, prog_full}, 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h5A);
    applyStimulus(1'b1, 1'b0, 8'h5B);
    checkOutput("post_reset_first", {24'd0, dout}, 32'h5A);
    repeat (2) applyStimulus(1'b0, 1'b1, 8'h00);

    // Randomized traffic with phases biased toward filling, draining and balance
    for (int i = 0; i < 600; i++) begin
      int pw;
      int pr;
      case ((i / 100) % 3)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 30; pr = 80; end
        default: begin pw = 60; pr = 60; end
      endcase
      applyStimulus($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom));
    end
    repeat (6) applyStimulus(1'b0, 1'b1, 8'h00);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fallthrough_fifo_small.md
FALLTHROUGH_FIFO_SMALL -- requirements
Module: fallthrough_fifo_small

Interface
REQ-001 The block SHALL have parameter WIDTH, default 72, meaning the data word width in bits.
REQ-002 The block SHALL have parameter MAX_DEPTH_BITS, default 3, meaning log2 of the depth (DEPTH = 2**MAX_DEPTH_BITS).
REQ-003 The block SHALL have parameter PROG_FULL_THRESHOLD, default DEPTH-1, meaning the occupancy at which prog_full asserts.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 Port reset: input, 1 bit, synchronous active-high reset.
REQ-007 Port din: input, WIDTH bits, write data.
REQ-008 Port wr_en: input, 1 bit, write request.
REQ-009 Port rd_en: input, 1 bit, read/pop request.
REQ-010 Port dout: output, WIDTH bits, head-of-queue data (fall-through).
REQ-011 Port full: output, 1 bit, occupancy == DEPTH.
REQ-012 Port nearly_full: output, 1 bit, occupancy >= DEPTH-1.
REQ-013 Port prog_full: output, 1 bit, occupancy >= PROG_FULL_THRESHOLD.
REQ-014 Port empty: output, 1 bit, occupancy == 0.

Function
REQ-015 The block SHALL store up to DEPTH words in FIFO order; internal occupancy counter width MAX_DEPTH_BITS+1.
REQ-016 A write SHALL be accepted when wr_en=1 and (full=0 or an accepted read occurs in the same cycle); din is captured at that edge.
REQ-017 A read SHALL be accepted when rd_en=1 and empty=0; the head word is popped at that edge.
REQ-018 Fall-through: whenever empty=0, dout SHALL equal the oldest stored word combinationally, with no rd_en needed to present it; dout is don't-care while empty=1.
REQ-019 Latency: a word written into an empty FIFO at edge N SHALL appear on dout with empty=0 after edge N (one-cycle write-to-visible).
REQ-020 After an accepted read, dout SHALL show the next word in the following cycle, or empty SHALL assert if none remains.
REQ-021 Simultaneous accepted read and write SHALL leave occupancy unchanged; when full, both are accepted and full stays 1.
REQ-022 Simultaneous wr_en and rd_en while empty: the write SHALL be accepted, the read ignored; occupancy becomes 1.
REQ-023 Write while full without a read (overflow) SHALL be dropped; storage, pointers and flags SHALL be unchanged.
REQ-024 Read while empty (underflow) SHALL be ignored; state SHALL be unchanged.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH with no gaps or duplication.
REQ-026 full, nearly_full, prog_full and empty SHALL be derived from the registered occupancy and update in the cycle after the causing edge.

Reset
REQ-027 While reset=1 at a clock edge, occupancy and both pointers SHALL clear to 0, giving empty=1, full=0, nearly_full=0 and prog_full=(PROG_FULL_THRESHOLD==0).
REQ-028 Reset SHALL take priority over simultaneous wr_en/rd_en; a mid-operation reset SHALL discard all stored words.
REQ-029 Memory contents need not be cleared by reset.

Verification (WIDTH=8, MAX_DEPTH_BITS=2, DEPTH=4, PROG_FULL_THRESHOLD=3)
REQ-030 Reset, then write 0xA5 once -> next cycle empty=0 and dout=0xA5; pulse rd_en -> next cycle empty=1.
REQ-031 Write 0x01,0x02,0x03 -> nearly_full=1, prog_full=1, full=0; write 0x04 -> full=1; write 0x05 -> dropped; reads then return 0x01,0x02,0x03,0x04 and empty=1.
REQ-032 With FIFO full (0x10..0x13), assert wr_en (din=0x14) and rd_en together -> full stays 1; subsequent reads return 0x11,0x12,0x13,0x14.
REQ-033 With FIFO empty, assert rd_en alone for 3 cycles -> empty stays 1 and no flag changes; then wr_en+rd_en with din=0x77 -> empty=0, dout=0x77.
REQ-034 Stream 10 words 0x00..0x09 with continuous interleaved writes and reads -> output order is 0x00..0x09 across pointer wrap-around, with no loss or duplication.
REQ-035 Load 3 words, assert reset for one cycle together with wr_en -> empty=1, full=0, nearly_full=0, prog_full=0; the next write of 0x5A is the first word read.
